// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between NREQ producers, the arbiter and the FIFO write port.
//   req       producer request bits, one per producer
//   data_i    packed producer data, producer i at [i*DW +: DW]
//   fifo_full FIFO full flag (backpressure)
//   w_en      write strobe into the FIFO
//   d_out     write data into the FIFO
//   gnt       one-hot pop strobe back to the producer being written
//   owner     index of the producer currently owning the port
//   busy      arbiter is in its granting state
// The slave modport is the arbiter's view; master is the environment's view.
interface fifo_wr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    localparam int OW = $clog2(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] data_i;
    logic               fifo_full;
    logic               w_en;
    logic [DW-1:0]      d_out;
    logic [NREQ-1:0]    gnt;
    logic [OW-1:0]      owner;
    logic               busy;

    modport master (
        output req, data_i, fifo_full,
        input  w_en, d_out, gnt, owner, busy
    );

    modport slave (
        input  req, data_i, fifo_full,
        output w_en, d_out, gnt, owner, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers.
// A producer keeps ownership for up to BURST written beats, or until it drops
// its request, then ownership rotates to the next requester after it.
// Writes are suppressed combinationally while fifo_full is high.
//   clk  system clock (rising edge)
//   rst  asynchronous active-high reset
//   bus  fifo_wr_arbiter_if slave: req/data_i/fifo_full in,
//        w_en/d_out/gnt/owner/busy out
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    fifo_wr_arbiter_if.slave    bus
);
    localparam int OW = $clog2(NREQ);
    localparam int CW = $clog2(BURST + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] last_q,  last_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    logic            w_en;
    logic [CW-1:0]   cnt_inc;
    logic            rel;
    logic [DW-1:0]   sel_data;
    logic [NREQ-1:0] gnt_v;

    // First set request bit strictly after ptr, wrapping; ptr itself is
    // scanned last so a lone requester gets re-picked.
    function automatic logic [OW-1:0] pick(input logic [NREQ-1:0] r,
                                           input logic [OW-1:0]   ptr);
        logic [OW-1:0] sel;
        logic [OW-1:0] cand;
        logic          found;
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = OW'((int'(ptr) + k) % NREQ);
            if (!found && r[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign w_en    = (state_q == GRANT) && bus.req[owner_q] && !bus.fifo_full;
    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == OW'(i)) sel_data = bus.data_i[i*DW +: DW];
        end
        gnt_v = '0;
        if (w_en) gnt_v[owner_q] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        rel     = 1'b0;

        if (state_q == IDLE) begin
            if (|bus.req) begin
                state_d = GRANT;
                owner_d = pick(bus.req, last_q);
                cnt_d   = '0;
            end
        end else begin
            // A full stall (req held, no write) neither counts nor releases.
            if (w_en) begin
                if (cnt_inc == CW'(BURST)) rel = 1'b1;
                else                       cnt_d = cnt_inc;
            end else if (!bus.req[owner_q]) begin
                rel = 1'b1;
            end
        end

        // Release hands over directly to the next requester, no bubble.
        // A dropped owner has req=0, so pick() skips it naturally.
        if (rel) begin
            last_d = owner_q;
            cnt_d  = '0;
            if (|bus.req) begin
                state_d = GRANT;
                owner_d = pick(bus.req, owner_q);
            end else begin
                state_d = IDLE;
                owner_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.w_en  = w_en;
    assign bus.d_out = w_en ? sel_data : '0;
    assign bus.gnt   = gnt_v;
    assign bus.owner = owner_q;
    assign bus.busy  = (state_q == GRANT);
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: cycle-by-cycle vector table, directed multi-cycle
// sequences, and randomized traffic against a burst-budget reference model.
module tb_fifo_wr_arbiter;
    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int BURST = 4;

    logic clk = 1'b0;
    logic rst;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] req;
        logic       full;
        logic       e_wen;
        logic [3:0] e_gnt;
        logic [1:0] e_own;
        logic       e_busy;
        logic [7:0] e_dout;
    } vec_t;

    vec_t vt[14];

    // Reference model: who owns the port and how many beats remain.
    bit m_busy;
    int m_owner;
    int m_left;
    int m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic wen, input logic [3:0] gnt,
                           input logic [1:0] own, input logic busy, input logic [7:0] dout);
        chk({tag, ".w_en"},  32'(bus.w_en),  32'(wen));
        chk({tag, ".gnt"},   32'(bus.gnt),   32'(gnt));
        chk({tag, ".owner"}, 32'(bus.owner), 32'(own));
        chk({tag, ".busy"},  32'(bus.busy),  32'(busy));
        chk({tag, ".d_out"}, 32'(bus.d_out), 32'(dout));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit bit_of(input logic [3:0] r, input int i);
        return ((r >> i) & 4'b0001) != 4'b0000;
    endfunction

    function automatic int rr_next(input logic [3:0] r, input int from);
        for (int k = 1; k <= NREQ; k++) begin
            if (bit_of(r, (from + k) % NREQ)) return (from + k) % NREQ;
        end
        return 0;
    endfunction

    task automatic m_reset();
        m_busy  = 0;
        m_owner = 0;
        m_left  = 0;
        m_last  = NREQ - 1;
    endtask

    task automatic do_reset(input logic [3:0] r);
        rst           = 1'b1;
        bus.req       = r;
        bus.fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
    endtask

    task automatic set_fixed_data();
        bus.data_i = {8'h13, 8'h12, 8'h11, 8'h10};
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r;
        logic       f;
        logic [31:0] d;
        bit          e_wen;
        logic [3:0]  e_gnt;
        logic [7:0]  e_dout;
        bit          give_up;

        rst           = 1'b1;
        bus.req       = '0;
        bus.fifo_full = 1'b0;
        set_fixed_data();

        // ---- Reset then idle: req all high during reset ----
        bus.req = 4'b1111;
        @(negedge clk);
        chk_out("rst_hold", 1'b0, 4'b0000, 2'd0, 1'b0, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_out("rst_arb", 1'b0, 4'b0000, 2'd0, 1'b0, 8'h00);
        tick();
        @(negedge clk);
        chk_out("rst_first", 1'b1, 4'b0001, 2'd0, 1'b1, 8'h10);

        // ---- Vector table: early drop, stall, empty release, idle restart ----
        vt[0]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 8'h00};
        vt[1]  = '{4'b0101, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 8'h00};
        vt[2]  = '{4'b0101, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 8'h10};
        vt[3]  = '{4'b0100, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b1, 8'h00};
        vt[4]  = '{4'b0101, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 8'h12};
        vt[5]  = '{4'b0101, 1'b1, 1'b0, 4'b0000, 2'd2, 1'b1, 8'h00};
        vt[6]  = '{4'b0101, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 8'h12};
        vt[7]  = '{4'b0101, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 8'h12};
        vt[8]  = '{4'b0101, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 8'h12};
        vt[9]  = '{4'b0101, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 8'h10};
        vt[10] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b1, 8'h00};
        vt[11] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 8'h00};
        vt[12] = '{4'b1000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 8'h00};
        vt[13] = '{4'b1000, 1'b0, 1'b1, 4'b1000, 2'd3, 1'b1, 8'h13};

        do_reset(4'b0000);
        for (int i = 0; i < 14; i++) begin
            bus.req       = vt[i].req;
            bus.fifo_full = vt[i].full;
            @(negedge clk);
            chk_out($sformatf("vec%0d", i), vt[i].e_wen, vt[i].e_gnt,
                    vt[i].e_own, vt[i].e_busy, vt[i].e_dout);
            tick();
        end

        // ---- Round-robin: 4 beats each, continuous writes, wraps to 0 ----
        do_reset(4'b1111);
        @(negedge clk);
        chk("rr_latency.w_en", 32'(bus.w_en), 32'd0);
        tick();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk($sformatf("rr%0d.w_en", k),  32'(bus.w_en),  32'd1);
            chk($sformatf("rr%0d.d_out", k), 32'(bus.d_out), 32'h10 + 32'((k / 4) % 4));
            chk($sformatf("rr%0d.gnt", k),   32'(bus.gnt),   32'd1 << ((k / 4) % 4));
            tick();
        end

        // ---- Backpressure: owner 1 stalled after 2 beats ----
        do_reset(4'b1111);
        tick();
        repeat (4) tick();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("bp_pre%0d.owner", k), 32'(bus.owner), 32'd1);
            chk($sformatf("bp_pre%0d.w_en", k),  32'(bus.w_en),  32'd1);
            tick();
        end
        bus.fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk_out($sformatf("bp_full%0d", k), 1'b0, 4'b0000, 2'd1, 1'b1, 8'h00);
            tick();
        end
        bus.fifo_full = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk_out($sformatf("bp_post%0d", k), 1'b1, 4'b0010, 2'd1, 1'b1, 8'h11);
            tick();
        end
        @(negedge clk);
        chk_out("bp_next", 1'b1, 4'b0100, 2'd2, 1'b1, 8'h12);

        // ---- Single requester wraps back to itself with no idle cycle ----
        do_reset(4'b1000);
        @(negedge clk);
        chk("single_latency.w_en", 32'(bus.w_en), 32'd0);
        tick();
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            chk_out($sformatf("single%0d", k), 1'b1, 4'b1000, 2'd3, 1'b1, 8'h13);
            tick();
        end

        // ---- Reset mid-burst: owner 2, third beat ----
        do_reset(4'b1111);
        repeat (11) tick();
        #2;
        chk("midrst_pre.owner", 32'(bus.owner), 32'd2);
        chk("midrst_pre.w_en",  32'(bus.w_en),  32'd1);
        rst = 1'b1;
        #1;
        chk_out("midrst_async", 1'b0, 4'b0000, 2'd0, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_idle.w_en", 32'(bus.w_en), 32'd0);
        tick();
        @(negedge clk);
        chk_out("midrst_restart", 1'b1, 4'b0001, 2'd0, 1'b1, 8'h10);
        tick();

        // ---- Randomized traffic against the reference model ----
        do_reset(4'b0000);
        r = 4'b0000;
        for (int c = 0; c < 600; c++) begin
            r = r ^ 4'($urandom & $urandom);
            f = ($urandom_range(0, 3) == 0);
            d = $urandom;
            bus.req       = r;
            bus.fifo_full = f;
            bus.data_i    = d;
            @(negedge clk);

            e_wen  = m_busy && bit_of(r, m_owner) && !f;
            e_gnt  = e_wen ? 4'(1 << m_owner) : 4'b0000;
            e_dout = e_wen ? 8'(d >> (8 * m_owner)) : 8'h00;
            chk_out($sformatf("rnd%0d", c), e_wen, e_gnt, 2'(m_owner), m_busy, e_dout);

            if (!m_busy) begin
                if (r != 4'b0000) begin
                    m_busy  = 1;
                    m_owner = rr_next(r, m_last);
                    m_left  = BURST;
                end
            end else begin
                give_up = 0;
                if (e_wen) begin
                    m_left--;
                    give_up = (m_left == 0);
                end else if (!bit_of(r, m_owner)) begin
                    give_up = 1;
                end
                if (give_up) begin
                    m_last = m_owner;
                    if (r != 4'b0000) begin
                        m_owner = rr_next(r, m_owner);
                        m_left  = BURST;
                    end else begin
                        m_busy  = 0;
                        m_owner = 0;
                    end
                end
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
